ellipse_program_sequencer: RTL

- Host-facing configuration controller placed directly upstream of the ellipse renderer in the pixel pipeline.
- Accepts complete shape descriptors (centre, radii, colour) over a valid/ready handshake and holds each one pending until the next frame boundary.
- At that boundary it stalls the pixel stream and injects the renderer's program beats (program_out=1, x_out=0, y_out=reg ID, data_out=value). It then resumes pixel pass-through, so a shape never changes mid-frame.

---
 rtl/ellipse_program_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ellipse_program_sequencer.sv
// rtl/ellipse_program_sequencer.sv - frame-synchronous ellipse renderer programming sequencer
// Optional ELLIPSE_SEQ_SKIP_UNCHANGED_EN: emit beats only for registers whose value changed.
module ellipse_program_sequencer #(
  parameter int X_W = 11,
  parameter int Y_W = 12,
  parameter int D_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [X_W-1:0] cfg_x_coord,
  input  logic [Y_W-1:0] cfg_y_coord,
  input  logic [X_W-1:0] cfg_width_rad,
  input  logic [Y_W-1:0] cfg_height_rad,
  input  logic [D_W-1:0] cfg_color,
  input  logic           pix_valid,
  output logic           pix_ready,
  input  logic           pix_sof,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic [D_W-1:0] pix_data,
  output logic           out_valid,
  output logic           program_out,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [D_W-1:0] data_out,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, PROG} state_t;

  state_t         state, state_nxt;
  logic [2:0]     reg_idx, reg_idx_nxt, emit_idx;
  logic           beat_emit, pix_accept, sof_seen;
  logic [X_W-1:0] x_coord_q, width_rad_q;
  logic [Y_W-1:0] y_coord_q, height_rad_q;
  logic [D_W-1:0] color_q;
  logic [D_W-1:0] field [5];
  logic [D_W-1:0] emit_val;

  assign field[0]   = D_W'(x_coord_q);
  assign field[1]   = D_W'(y_coord_q);
  assign field[2]   = D_W'(width_rad_q);
  assign field[3]   = D_W'(height_rad_q);
  assign field[4]   = color_q;

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign sof_seen   = pix_valid & pix_sof;
  assign pix_accept = pix_valid & pix_ready;

  always_comb begin
    emit_val = '0;
    case (emit_idx)
      3'd0:    emit_val = field[0];
      3'd1:    emit_val = field[1];
      3'd2:    emit_val = field[2];
      3'd3:    emit_val = field[3];
      3'd4:    emit_val = field[4];
      default: emit_val = '0;
    endcase
  end

`ifdef ELLIPSE_SEQ_SKIP_UNCHANGED_EN
  logic [D_W-1:0] shadow [5];
  logic [4:0]     diff;
  logic           first_found, next_found;
  logic [2:0]     first_idx, next_idx;

  always_comb begin
    diff = '0;
    for (int i = 0; i < 5; i++) diff[i] = (field[i] != shadow[i]);
  end

  always_comb begin
    first_found = 1'b0;
    first_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (diff[i]) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
    end
  end

  assign emit_idx = (state == PROG) ? reg_idx : first_idx;

  // Next changed register strictly above the one going out this cycle.
  always_comb begin
    next_found = 1'b0;
    next_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (diff[i] && (3'(i) > emit_idx)) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  // Shadow reset values mirror the renderer's own power-on register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      shadow[4] <= '1;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (beat_emit && (emit_idx == 3'(i))) shadow[i] <= field[i];
      end
    end
  end
`else
  assign emit_idx = (state == PROG) ? reg_idx : 3'd0;
`endif

  // The SOF cycle itself carries the first beat, so stall length equals beat count.
  always_comb begin
    state_nxt   = state;
    reg_idx_nxt = reg_idx;
    pix_ready   = 1'b0;
    beat_emit   = 1'b0;
    case (state)
      IDLE: begin
        pix_ready = 1'b1;
        if (cfg_valid) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        pix_ready = !sof_seen;
        if (sof_seen) begin
`ifdef ELLIPSE_SEQ_SKIP_UNCHANGED_EN
          if (!first_found) begin
            pix_ready = 1'b1;
            state_nxt = IDLE;
          end else begin
            beat_emit = 1'b1;
            if (next_found) begin
              state_nxt   = PROG;
              reg_idx_nxt = next_idx;
            end else begin
              state_nxt   = IDLE;
            end
          end
`else
          beat_emit   = 1'b1;
          state_nxt   = PROG;
          reg_idx_nxt = 3'd1;
`endif
        end
      end
      PROG: begin
        beat_emit = 1'b1;
`ifdef ELLIPSE_SEQ_SKIP_UNCHANGED_EN
        if (next_found) begin
          reg_idx_nxt = next_idx;
        end else begin
          state_nxt   = IDLE;
          reg_idx_nxt = 3'd0;
        end
`else
        if (reg_idx == 3'd4) begin
          state_nxt   = IDLE;
          reg_idx_nxt = 3'd0;
        end else begin
          reg_idx_nxt = reg_idx + 3'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      reg_idx      <= 3'd0;
      x_coord_q    <= '0;
      y_coord_q    <= '0;
      width_rad_q  <= '0;
      height_rad_q <= '0;
      color_q      <= '0;
    end else begin
      state   <= state_nxt;
      reg_idx <= reg_idx_nxt;
      if (cfg_valid && cfg_ready) begin
        x_coord_q    <= cfg_x_coord;
        y_coord_q    <= cfg_y_coord;
        width_rad_q  <= cfg_width_rad;
        height_rad_q <= cfg_height_rad;
        color_q      <= cfg_color;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
    end else begin
      out_valid   <= pix_accept | beat_emit;
      program_out <= beat_emit;
      if (beat_emit) begin
        x_out    <= '0;
        y_out    <= Y_W'(emit_idx);
        data_out <= emit_val;
      end else if (pix_accept) begin
        x_out    <= pix_x;
        y_out    <= pix_y;
        data_out <= pix_data;
      end
    end
  end

endmodule
